// File: rtl/mem_pkg.sv
// Shared types and constants for the multi-cycle memory responder.
// Used by mem_responder, mem_arb and the handshake interface.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic PORT_I      = 1'b0;
    localparam logic PORT_D      = 1'b1;
    localparam int   LAT_DEFAULT = 4;
    localparam int   WORD_W      = 16;
    localparam int   CNT_W       = 4;

endpackage

// File: rtl/mem_responder_if.sv
// Instruction/data request-ack-response bundle between the pipeline and mem_responder.
// slave = responder side, master = pipeline side.
interface mem_responder_if;
    import mem_pkg::*;

    logic              i_req;
    logic [WORD_W-1:0] i_addr;
    logic              i_ack;
    logic              i_rsp_valid;
    logic [WORD_W-1:0] i_rdata;

    logic              d_req;
    logic              d_wr;
    logic [WORD_W-1:0] d_addr;
    logic [WORD_W-1:0] d_wdata;
    logic              d_ack;
    logic              d_rsp_valid;
    logic [WORD_W-1:0] d_rdata;

    logic              busy;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
        output i_ack, i_rsp_valid, i_rdata, d_ack, d_rsp_valid, d_rdata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
        input  i_ack, i_rsp_valid, i_rdata, d_ack, d_rsp_valid, d_rdata, busy
    );

endinterface

// File: rtl/mem_arb.sv
// Two-way I/D arbiter producing a one-hot grant (bit PORT_I / bit PORT_D).
// MEM_RESP_RR_ARB_EN selects round-robin on ties; otherwise D has fixed priority.
module mem_arb
    import mem_pkg::*;
(
    input  logic       i_i_req,
    input  logic       i_d_req,
    input  logic       i_en,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        if (i_en) begin
`ifdef MEM_RESP_RR_ARB_EN
            if (i_i_req && i_d_req) begin
                // On a tie, hand the grant to whichever port did not win last time
                o_grant = (i_last_grant == PORT_D) ? 2'b01 : 2'b10;
            end else begin
                o_grant = {i_d_req, i_i_req};
            end
`else
            if (i_d_req) begin
                o_grant = 2'b10;
            end else if (i_i_req) begin
                o_grant = 2'b01;
            end
`endif
        end
    end

`ifndef MEM_RESP_RR_ARB_EN
    logic w_unused_last;
    assign w_unused_last = i_last_grant;
`endif

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency, single-outstanding memory shared by the I-fetch and D ports.
// Optional round-robin arbitration via MEM_RESP_RR_ARB_EN (see mem_arb).
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LAT    = LAT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_responder_if.slave  bus
);

    logic [WORD_W-1:0] r_mem [2**ADDR_W];

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_port;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wr;
    logic [WORD_W-1:0] r_wdata;
    logic              r_i_rsp_valid;
    logic              r_d_rsp_valid;
    logic [WORD_W-1:0] r_i_rdata;
    logic [WORD_W-1:0] r_d_rdata;

    logic [1:0]        w_grant;
    logic              w_accept;
    logic              w_grant_port;
    logic              w_last_grant;
    logic              w_fire;
    logic              w_op_port;
    logic [ADDR_W-1:0] w_op_addr;
    logic              w_op_wr;
    logic [WORD_W-1:0] w_op_wdata;

`ifdef MEM_RESP_RR_ARB_EN
    logic r_last_grant;
    assign w_last_grant = r_last_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= PORT_I;
        end else if (w_accept) begin
            r_last_grant <= w_grant_port;
        end
    end
`else
    assign w_last_grant = PORT_I;
`endif

    mem_arb u_arb (
        .i_i_req      (bus.i_req),
        .i_d_req      (bus.d_req),
        .i_en         (r_state == IDLE),
        .i_last_grant (w_last_grant),
        .o_grant      (w_grant)
    );

    assign w_accept     = |w_grant;
    assign w_grant_port = w_grant[PORT_D] ? PORT_D : PORT_I;

    // In IDLE the op fields come straight from the winning port so LAT=1 can
    // perform the access on the acceptance edge; otherwise use the captured copy.
    always_comb begin
        w_op_port  = r_port;
        w_op_addr  = r_addr;
        w_op_wr    = r_wr;
        w_op_wdata = r_wdata;
        w_fire     = 1'b0;
        if (r_state == IDLE) begin
            w_op_port  = w_grant_port;
            w_op_addr  = (w_grant_port == PORT_D) ? bus.d_addr[ADDR_W:1] : bus.i_addr[ADDR_W:1];
            w_op_wr    = (w_grant_port == PORT_D) && bus.d_wr;
            w_op_wdata = bus.d_wdata;
            w_fire     = (LAT == 1) && w_accept;
        end else if (r_state == BUSY) begin
            w_fire     = (r_cnt == CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire && w_op_wr) begin
            r_mem[w_op_addr] <= w_op_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_port        <= PORT_I;
            r_addr        <= '0;
            r_wr          <= 1'b0;
            r_wdata       <= '0;
            r_i_rsp_valid <= 1'b0;
            r_d_rsp_valid <= 1'b0;
            r_i_rdata     <= '0;
            r_d_rdata     <= '0;
        end else begin
            r_i_rsp_valid <= w_fire && (w_op_port == PORT_I);
            r_d_rsp_valid <= w_fire && (w_op_port == PORT_D);
            if (w_fire && !w_op_wr) begin
                if (w_op_port == PORT_D) begin
                    r_d_rdata <= r_mem[w_op_addr];
                end else begin
                    r_i_rdata <= r_mem[w_op_addr];
                end
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_port  <= w_op_port;
                        r_addr  <= w_op_addr;
                        r_wr    <= w_op_wr;
                        r_wdata <= w_op_wdata;
                        r_cnt   <= CNT_W'(LAT - 1);
                        r_state <= (LAT == 1) ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_fire) begin
                        r_state <= RESP;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.i_ack       = w_grant[PORT_I];
    assign bus.d_ack       = w_grant[PORT_D];
    assign bus.i_rsp_valid = r_i_rsp_valid;
    assign bus.d_rsp_valid = r_d_rsp_valid;
    assign bus.i_rdata     = r_i_rdata;
    assign bus.d_rdata     = r_d_rdata;
    assign bus.busy        = (r_state != IDLE);

    // Byte-offset bit and bits above the array size alias by design
    logic w_unused_addr;
    assign w_unused_addr = ^{bus.i_addr[0], bus.d_addr[0],
                             bus.i_addr[WORD_W-1:ADDR_W+1], bus.d_addr[WORD_W-1:ADDR_W+1]};

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Multi-cycle main-memory responder. It services the pipeline's instruction-fetch port (read-only) and data-memory port (read/write) behind a req/ack/rsp_valid handshake.
- It replaces single-cycle memory with a fixed-latency, single-outstanding-transaction model shared by both ports.
- It sits below the IF and MEM stages. Pipeline stall logic keys off ack and rsp_valid.

Parameters:
- ADDR_W, 10, word-index width; array holds 2^ADDR_W 16-bit words.
- LAT, 4, cycles from acceptance to response; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_req  in  1  instruction read request; held until i_ack
- i_addr  in  16  instruction byte address
- i_ack  out  1  instruction request accepted (one-cycle pulse)
- i_rsp_valid  out  1  instruction read data valid (one-cycle pulse)
- i_rdata  out  16  instruction read data
- d_req  in  1  data request; held until d_ack
- d_wr  in  1  1 = write, 0 = read
- d_addr  in  16  data byte address
- d_wdata  in  16  write data
- d_ack  out  1  data request accepted (one-cycle pulse)
- d_rsp_valid  out  1  data completion; read data valid when the request was a read
- d_rdata  out  16  data read data
- busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - All outputs 0 (i_rdata and d_rdata = 16'h0000).
  - Latency counter = 0; last-grant pointer = I-port.
  - Memory array is NOT cleared.
- Address mapping: word index = addr[ADDR_W:1]; addr[0] is ignored; upper bits beyond ADDR_W+1 are ignored (aliasing/wrap).
- FSM states:
  - IDLE: if any req is high, grant one port. Assert that port's ack combinationally in this cycle. At the edge, capture port, addr, wr and wdata, load cnt = LAT-1, and go to BUSY. With no req, stay in IDLE.
  - BUSY: cnt decrements each cycle. When cnt == 0, at that edge:
    - Perform the op: write commits to the array, or read data is registered into the granted port's rdata.
    - The granted port's rsp_valid registers to 1.
    - Go to RESP.
  - RESP: rsp_valid is high for exactly this cycle; rdata holds the value. Go to IDLE at the next edge. No acceptance in RESP.
- Timing:
  - Acceptance edge ends cycle T; rsp_valid is high in cycle T+LAT.
  - Next possible ack is cycle T+LAT+1; throughput is one transaction per LAT+1 cycles.
  - LAT=1: go straight from IDLE to the op edge; RESP is in cycle T+1.
- rdata holds its last value until the next read response on that port.
- d_rdata is unchanged on a write response.
- Arbitration (default, fixed priority): D-port wins when both req are high in IDLE. The losing req stays pending and is served next IDLE.
- Requests are captured at acceptance only. Changes to addr/wdata after ack do not affect the transaction.
- Read-after-write to the same address in consecutive transactions returns the new data.
- Reset mid-transaction: the transaction is dropped and no rsp_valid is issued. A write not yet committed (its commit edge has not occurred) is lost.
- Protocol violation (req deasserted before ack): ignored; it is only sampled in IDLE.

Optional Feature:
- Macro: MEM_RESP_RR_ARB_EN.
- Defined: round-robin arbitration. On simultaneous requests, grant the port NOT granted last. The last-grant pointer updates on each acceptance and resets to I-port, so D wins the first tie after reset.
- Undefined: fixed D-over-I priority as above; the pointer logic is absent.

Decomposition:
- Shared package mem_pkg:
  - FSM state enum {IDLE, BUSY, RESP}
  - port-select constants PORT_I = 1'b0, PORT_D = 1'b1
  - default LAT
  - WORD_W = 16
- One natural sub-module: mem_arb. It is a 2-way arbiter (fixed or round-robin per macro) taking i_req, d_req, enable and last_grant, and producing a one-hot grant.
- The array and FSM stay in mem_responder.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release with no req → all outputs 0, busy=0 for 5 cycles.
- Write then read, LAT=4:
  - D write addr 16'h0010, data 16'hBEEF accepted in cycle T → d_rsp_valid in T+4.
  - D read of 16'h0011 accepted at T+5 → d_rsp_valid at T+9 with d_rdata=16'hBEEF.
- I fetch: preload word 5 = 16'h1234; i_addr=16'h000A → i_ack one cycle, i_rsp_valid LAT cycles later, i_rdata=16'h1234, d_rsp_valid stays 0.
- Contention: i_req and d_req high together in IDLE.
  - Fixed priority: d_ack first, i_ack at T+LAT+1.
  - MEM_RESP_RR_ARB_EN, repeated contention: grants alternate D, I, D, I.
- Reset mid-op: D write 16'hAAAA to 16'h0020 accepted, then rst_n=0 at T+2 → no d_rsp_valid; a later read of 16'h0020 returns the pre-existing value, not 16'hAAAA.
- LAT=1 and alias: write addr 16'h0000, then read addr 16'h0001 and addr 1<<(ADDR_W+1) → each response arrives in the cycle after ack and returns the written data.
